action_table_ctrl: RTL and testbench

- Sequencer and arbiter for the single-port action-table RAM in the match-action stage.
- Shares the RAM between datapath lookups, which follow flow_table hits, and AXI4-Lite config reads and writes.
- Sweeps the table to zero after reset and on request, replacing the per-entry reset of the array.
- Returns the decoded action and a tag-match flag per lookup, in order, with fixed latency.

---
 rtl/action_table_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_action_table_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : action_table_ctrl
// Brief    : Arbiter/sequencer for the single-port action-table RAM: datapath
//            lookups, AXI4-Lite style config access and a zeroing sweep.
// Revision : 1.0 - initial release
// ============================================================================
module action_table_ctrl #(
    parameter int IDX_W      = 10,
    parameter int ENTRY_W    = 26,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lkp_valid,
    output logic               lkp_ready,
    input  logic               lkp_hit,
    input  logic [15:0]        lkp_flow_id,
    output logic               res_valid,
    output logic               res_match,
    output logic [8:0]         res_action,
    output logic [15:0]        res_flow_id,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [15:0]        cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic               cfg_ack,
    output logic [31:0]        cfg_rdata,
    input  logic               cfg_clr,
    output logic               busy,
    output logic               ram_en,
    output logic               ram_we,
    output logic [IDX_W-1:0]   ram_addr,
    output logic [ENTRY_W-1:0] ram_wdata,
    input  logic [ENTRY_W-1:0] ram_rdata
);

    localparam int                c_ST_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_ST_W-1:0] c_STARVE    = c_ST_W'(STARVE_MAX);
    localparam logic [IDX_W-1:0]  c_IDX_LAST  = '1;

    typedef enum logic [0:0] {
        S_CLR = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [c_ST_W-1:0]  r_starve;
    logic               r_busy;
    logic               r_cfg_out;
    logic               r_clr_pend;
    logic               r_p1_valid;
    logic               r_p1_hit;
    logic [15:0]        r_p1_flow;
    logic               r_rd_p1;
    logic               r_res_valid;
    logic               r_res_match;
    logic [8:0]         r_res_action;
    logic [15:0]        r_res_flow;
    logic               r_cfg_ack;
    logic [31:0]        r_cfg_rdata;

    logic               w_run_ok;
    logic               w_cfg_pend;
    logic               w_cfg_gnt;
    logic               w_cfg_rd;
    logic               w_lkp_ready;
    logic               w_lkp_acc;
    logic               w_drain_done;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [8:0]         w_ent_act;
    logic               w_ent_valid;
    logic [15:0]        w_ent_flow;
    logic               w_match;
    logic               w_unused_ok;

    // Arbitration is only open in RUN, and closes as soon as a clear is pending.
    assign w_run_ok     = !rst && (r_state == S_RUN) && !r_clr_pend;
    assign w_cfg_pend   = (cfg_we || cfg_re) && !r_cfg_out;
    assign w_cfg_gnt    = w_run_ok && w_cfg_pend && (!lkp_valid || (r_starve == c_STARVE));
    assign w_cfg_rd     = w_cfg_gnt && !cfg_we;
    assign w_lkp_ready  = w_run_ok && !w_cfg_gnt;
    assign w_lkp_acc    = lkp_valid && w_lkp_ready;
    assign w_drain_done = r_clr_pend && !r_p1_valid && !r_rd_p1 && !r_cfg_out;

    assign w_wr_entry = {cfg_wdata[0], cfg_wdata[1], cfg_wdata[2], cfg_wdata[6:3],
                         cfg_wdata[7], cfg_wdata[8], 1'b1, cfg_addr};

    assign w_ent_act   = {ram_rdata[17], ram_rdata[18], ram_rdata[22:19],
                          ram_rdata[23], ram_rdata[24], ram_rdata[25]};
    assign w_ent_valid = ram_rdata[16];
    assign w_ent_flow  = ram_rdata[15:0];
    assign w_match     = r_p1_hit && w_ent_valid && (w_ent_flow == r_p1_flow);

    assign w_unused_ok = ^cfg_wdata[31:9];

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = lkp_flow_id[IDX_W-1:0];
        ram_wdata = '0;
        if (!rst) begin
            if (r_state == S_CLR) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_idx;
            end else if (w_cfg_gnt) begin
                ram_en   = 1'b1;
                ram_we   = cfg_we;
                ram_addr = cfg_addr[IDX_W-1:0];
                if (cfg_we) begin
                    ram_wdata = w_wr_entry;
                end
            end else if (w_lkp_acc && lkp_hit) begin
                ram_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CLR;
            r_idx        <= '0;
            r_busy       <= 1'b1;
            r_starve     <= '0;
            r_cfg_out    <= 1'b0;
            r_clr_pend   <= 1'b0;
            r_p1_valid   <= 1'b0;
            r_p1_hit     <= 1'b0;
            r_p1_flow    <= '0;
            r_rd_p1      <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_match  <= 1'b0;
            r_res_action <= '0;
            r_res_flow   <= '0;
            r_cfg_ack    <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_p1_valid <= w_lkp_acc;
            r_p1_hit   <= w_lkp_acc && lkp_hit;
            r_p1_flow  <= lkp_flow_id;
            r_rd_p1    <= w_cfg_rd;

            r_res_valid  <= r_p1_valid;
            r_res_match  <= r_p1_valid && w_match;
            r_res_action <= (r_p1_valid && w_match) ? w_ent_act : 9'd0;
            r_res_flow   <= r_p1_valid ? r_p1_flow : 16'd0;

            r_cfg_ack <= (w_cfg_gnt && cfg_we) || r_rd_p1;
            if (r_rd_p1) begin
                r_cfg_rdata <= {w_ent_flow, 6'd0, w_ent_valid, w_ent_act};
            end

            // Outstanding stays set through the ack cycle so a held request is not regranted.
            if (w_cfg_gnt) begin
                r_cfg_out <= 1'b1;
            end else if (r_cfg_ack) begin
                r_cfg_out <= 1'b0;
            end

            if (w_cfg_gnt) begin
                r_starve <= '0;
            end else if (w_cfg_pend && w_lkp_acc && (r_starve != c_STARVE)) begin
                r_starve <= r_starve + 1'b1;
            end

            case (r_state)
                S_CLR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (cfg_clr && !r_clr_pend) begin
                        r_clr_pend <= 1'b1;
                    end else if (w_drain_done) begin
                        r_clr_pend <= 1'b0;
                        r_state    <= S_CLR;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign lkp_ready   = w_lkp_ready;
    assign res_valid   = r_res_valid;
    assign res_match   = r_res_match;
    assign res_action  = r_res_action;
    assign res_flow_id = r_res_flow;
    assign cfg_ack     = r_cfg_ack;
    assign cfg_rdata   = r_cfg_rdata;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_action_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_action_table_ctrl
// Brief    : Self-checking bench for action_table_ctrl with a RAM model and an
//            abstract table/result-queue reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_action_table_ctrl;

    localparam int IDX_W      = 10;
    localparam int ENTRY_W    = 26;
    localparam int STARVE_MAX = 8;
    localparam int DEPTH      = 1 << IDX_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               lkp_valid, lkp_ready, lkp_hit;
    logic [15:0]        lkp_flow_id;
    logic               res_valid, res_match;
    logic [8:0]         res_action;
    logic [15:0]        res_flow_id;
    logic               cfg_we, cfg_re, cfg_ack, cfg_clr, busy;
    logic [15:0]        cfg_addr;
    logic [31:0]        cfg_wdata, cfg_rdata;
    logic               ram_en, ram_we;
    logic [IDX_W-1:0]   ram_addr;
    logic [ENTRY_W-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    action_table_ctrl #(.IDX_W(IDX_W), .ENTRY_W(ENTRY_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_hit(lkp_hit), .lkp_flow_id(lkp_flow_id),
        .res_valid(res_valid), .res_match(res_match), .res_action(res_action), .res_flow_id(res_flow_id),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata), .cfg_clr(cfg_clr), .busy(busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Single-port RAM, one-cycle read latency, power-up contents are garbage.
    logic [ENTRY_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference: what software believes each table slot holds.
    logic       m_valid [DEPTH];
    logic [15:0] m_flow [DEPTH];
    logic [8:0]  m_act  [DEPTH];

    typedef struct {
        int          due;
        logic [15:0] flow;
        logic        match;
        logic [8:0]  act;
    } exp_t;
    exp_t q[$];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic mon_en = 1'b0;
    logic cur_is_write = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_flow[i]  = '0;
            m_act[i]   = '0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        int ix = int'(a[IDX_W-1:0]);
        return {m_flow[ix], 6'd0, m_valid[ix], m_act[ix]};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        int   ix;
        cyc++;
        if (mon_en) begin
            if (cfg_ack) begin
                ix = int'(cfg_addr[IDX_W-1:0]);
                if (cur_is_write) begin
                    m_valid[ix] = 1'b1;
                    m_flow[ix]  = cfg_addr;
                    m_act[ix]   = cfg_wdata[8:0];
                end else begin
                    chk("mon_cfg_rdata", cfg_rdata, exp_rd(cfg_addr));
                end
            end
            if (lkp_valid && lkp_ready) begin
                ix      = int'(lkp_flow_id[IDX_W-1:0]);
                e.due   = cyc + 2;
                e.flow  = lkp_flow_id;
                e.match = lkp_hit && m_valid[ix] && (m_flow[ix] == lkp_flow_id);
                e.act   = e.match ? m_act[ix] : 9'd0;
                q.push_back(e);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("mon_res_valid", res_valid, 1);
                chk("mon_res_flow", res_flow_id, e.flow);
                chk("mon_res_match", res_match, e.match);
                chk("mon_res_action", res_action, e.act);
            end else begin
                chk("mon_res_idle", res_valid, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_op(input logic we, input logic re, input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        cur_is_write = we;
        cfg_we = we; cfg_re = re; cfg_addr = a; cfg_wdata = wd;
        lat = -1; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cfg_ack) begin lat = i; rd = cfg_rdata; break; end
        end
        tick();
        cfg_we = 1'b0; cfg_re = 1'b0;
        if (lat < 0) begin
            n_vec++; n_bad++;
            $display("FAIL cfg_timeout: got no ack, expected ack for addr 0x%0h", a);
        end
    endtask

    task automatic do_lookup(input logic [15:0] f, input logic h,
                             output logic m, output logic [8:0] a, output int lat);
        logic acc = 1'b0;
        lkp_valid = 1'b1; lkp_flow_id = f; lkp_hit = h;
        m = 1'b0; a = '0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lkp_ready) begin acc = 1'b1; break; end
        end
        tick();
        lkp_valid = 1'b0;
        if (acc) begin
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (res_valid && lat < 0) begin lat = k; m = res_match; a = res_action; end
                if (k < 4) tick();
            end
            tick();
        end
    endtask

    function automatic logic [15:0] pick_id();
        case ($urandom_range(0, 7))
            0: return 16'h0005;
            1: return 16'h0405;
            2: return 16'h0123;
            3: return 16'h0007;
            4: return 16'h0001;
            5: return 16'h0002;
            6: return 16'h03FF;
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        int          op;      // 0 write, 1 read, 2 lookup, 3 write with read also raised
        logic [15:0] a;
        logic [31:0] wd;
        logic        hit;
        logic [31:0] e_rd;
        logic        e_m;
        logic [8:0]  e_act;
    } vec_t;
    vec_t tv [16];

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd;
        logic        m, acc, ackd, cfg_act;
        logic [8:0]  a;
        int          lat, cnt, acc_n, gnt_c, ack_c, low_n, pulses, first_c, last_c, age;

        tv[0]  = '{0, 16'h0005, 32'h10A, 1'b0, 32'h0,        1'b0, 9'h000};
        tv[1]  = '{1, 16'h0005, 32'h0,   1'b0, 32'h0005030A, 1'b0, 9'h000};
        tv[2]  = '{2, 16'h0005, 32'h0,   1'b1, 32'h0,        1'b1, 9'h10A};
        tv[3]  = '{2, 16'h0405, 32'h0,   1'b1, 32'h0,        1'b0, 9'h000};
        tv[4]  = '{2, 16'h0005, 32'h0,   1'b0, 32'h0,        1'b0, 9'h000};
        tv[5]  = '{0, 16'h0123, 32'h1FF, 1'b0, 32'h0,        1'b0, 9'h000};
        tv[6]  = '{1, 16'h0123, 32'h0,   1'b0, 32'h012303FF, 1'b0, 9'h000};
        tv[7]  = '{2, 16'h0123, 32'h0,   1'b1, 32'h0,        1'b1, 9'h1FF};
        tv[8]  = '{0, 16'h03FF, 32'h001, 1'b0, 32'h0,        1'b0, 9'h000};
        tv[9]  = '{1, 16'h03FF, 32'h0,   1'b0, 32'h03FF0201, 1'b0, 9'h000};
        tv[10] = '{2, 16'h03FF, 32'h0,   1'b1, 32'h0,        1'b1, 9'h001};
        tv[11] = '{1, 16'h0000, 32'h0,   1'b0, 32'h0,        1'b0, 9'h000};
        tv[12] = '{3, 16'h0007, 32'h055, 1'b0, 32'h0,        1'b0, 9'h000};
        tv[13] = '{1, 16'h0007, 32'h0,   1'b0, 32'h00070255, 1'b0, 9'h000};
        tv[14] = '{2, 16'h0007, 32'h0,   1'b1, 32'h0,        1'b1, 9'h055};
        tv[15] = '{1, 16'h0405, 32'h0,   1'b0, 32'h0005030A, 1'b0, 9'h000};

        for (int i = 0; i < DEPTH; i++) mem[i] <= ENTRY_W'($urandom);
        rst = 1'b1; lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_flow_id = '0;
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_clr = 1'b0;
        model_clear();

        repeat (3) tick();
        @(negedge clk);
        chk("rst_lkp_ready", lkp_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_cfg_rdata", cfg_rdata, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ram_en", ram_en, 0);
        tick();
        rst = 1'b0;

        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) cnt++; else break;
        end
        chk("init_sweep_cycles", cnt, 1024);
        tick();
        mon_en = 1'b1;

        foreach (tv[i]) begin
            if (i == 0) begin
                cfg_op(1'b0, 1'b1, 16'h0000, 0, rd, lat); chk("sweep_rd_0", rd, 0);
                cfg_op(1'b0, 1'b1, 16'h0001, 0, rd, lat); chk("sweep_rd_1", rd, 0);
                cfg_op(1'b0, 1'b1, 16'h0155, 0, rd, lat); chk("sweep_rd_155", rd, 0);
                cfg_op(1'b0, 1'b1, 16'h0200, 0, rd, lat); chk("sweep_rd_200", rd, 0);
                cfg_op(1'b0, 1'b1, 16'h03FF, 0, rd, lat); chk("sweep_rd_3ff", rd, 0);
            end
            case (tv[i].op)
                0, 3: begin
                    cfg_op(1'b1, tv[i].op == 3, tv[i].a, tv[i].wd, rd, lat);
                    chk($sformatf("vec%0d_wr_latency", i), lat, 2);
                end
                1: begin
                    cfg_op(1'b0, 1'b1, tv[i].a, 0, rd, lat);
                    chk($sformatf("vec%0d_rd_latency", i), lat, 3);
                    chk($sformatf("vec%0d_rdata", i), rd, tv[i].e_rd);
                end
                default: begin
                    do_lookup(tv[i].a, tv[i].hit, m, a, lat);
                    chk($sformatf("vec%0d_lkp_latency", i), lat, 2);
                    chk($sformatf("vec%0d_match", i), m, tv[i].e_m);
                    chk($sformatf("vec%0d_action", i), a, tv[i].e_act);
                end
            endcase
        end

        // Lookup in the cycle right after a config write sees the new entry.
        cur_is_write = 1'b1;
        cfg_we = 1'b1; cfg_addr = 16'h0011; cfg_wdata = 32'h0C3;
        @(negedge clk);
        chk("wr_fwd_grant", ram_en && ram_we, 1);
        tick();
        lkp_valid = 1'b1; lkp_flow_id = 16'h0011; lkp_hit = 1'b1;
        @(negedge clk);
        chk("wr_fwd_ack", cfg_ack, 1);
        chk("wr_fwd_accept", lkp_ready, 1);
        tick();
        cfg_we = 1'b0; lkp_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("wr_fwd_res_match", res_valid && res_match, 1);
        chk("wr_fwd_res_action", res_action, 9'h0C3);
        tick();

        // Starvation bound with lookups held valid.
        lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_flow_id = 16'h0005;
        cur_is_write = 1'b1; cfg_we = 1'b1; cfg_re = 1'b0; cfg_addr = 16'h0009; cfg_wdata = 32'h0AA;
        acc_n = 0; gnt_c = -1; ack_c = -1; low_n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!lkp_ready) begin
                low_n++;
                if (gnt_c < 0) gnt_c = c;
            end else if (gnt_c < 0) begin
                acc_n++;
            end
            if (cfg_ack && ack_c < 0) ack_c = c;
            tick();
            if (ack_c > 0) cfg_we = 1'b0;
        end
        lkp_valid = 1'b0;
        chk("starve_accepts", acc_n, 8);
        chk("starve_grant_cycle", gnt_c, 9);
        chk("starve_ack_cycle", ack_c, 10);
        chk("starve_ready_low", low_n, 1);
        repeat (3) tick();

        // Back-to-back lookups deliver consecutive, ordered results.
        pulses = 0; first_c = -1; last_c = -1;
        for (int c = 1; c <= 8; c++) begin
            lkp_valid = (c <= 4); lkp_hit = 1'b1; lkp_flow_id = 16'(c);
            @(negedge clk);
            if (c <= 4) chk("b2b_ready", lkp_ready, 1);
            if (res_valid) begin
                pulses++;
                if (first_c < 0) first_c = c;
                last_c = c;
                chk("b2b_order", res_flow_id, pulses);
            end
            tick();
        end
        lkp_valid = 1'b0;
        chk("b2b_pulses", pulses, 4);
        chk("b2b_first", first_c, 3);
        chk("b2b_last", last_c, 6);

        // Random traffic against the reference.
        cfg_act = 1'b0; age = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc  = lkp_valid && lkp_ready;
            ackd = cfg_ack;
            tick();
            if (acc || !lkp_valid) begin
                lkp_valid   = ($urandom_range(0, 3) != 0);
                lkp_hit     = ($urandom_range(0, 3) != 0);
                lkp_flow_id = pick_id();
            end
            if (cfg_act) begin
                if (ackd) begin
                    chk("rnd_cfg_wait", age <= 12, 1);
                    cfg_we = 1'b0; cfg_re = 1'b0; cfg_act = 1'b0;
                end else begin
                    age++;
                    if (age > 40) begin
                        n_vec++; n_bad++;
                        $display("FAIL rnd_cfg_timeout: got no ack after %0d cycles, expected ack", age);
                        cfg_we = 1'b0; cfg_re = 1'b0; cfg_act = 1'b0;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'($urandom_range(0, 1));
                cfg_re = cfg_we ? 1'($urandom_range(0, 1)) : 1'b1;
                cfg_addr = pick_id();
                cfg_wdata = $urandom;
                cur_is_write = cfg_we;
                cfg_act = 1'b1; age = 0;
            end
        end
        lkp_valid = 1'b0;
        if (cfg_act) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cfg_ack) break;
            end
            tick();
            cfg_we = 1'b0; cfg_re = 1'b0;
        end
        repeat (4) tick();
        chk("rnd_queue_drained", q.size(), 0);

        // Clear with two lookups in flight.
        lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_flow_id = 16'h0005;
        @(negedge clk);
        chk("clr_lkp1_ready", lkp_ready, 1);
        tick();
        lkp_flow_id = 16'h0123; cfg_clr = 1'b1;
        @(negedge clk);
        chk("clr_lkp2_ready", lkp_ready, 1);
        tick();
        cfg_clr = 1'b0; lkp_flow_id = 16'h0007;
        pulses = 0; cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) begin cnt = 1; break; end
            chk("clr_drain_ready", lkp_ready, 0);
            if (res_valid) pulses++;
            tick();
        end
        chk("clr_results_before_sweep", pulses, 2);
        chk("clr_sweep_ready", lkp_ready, 0);
        tick();
        lkp_valid = 1'b0;
        for (int i = 0; i < 3000 && cnt > 0; i++) begin
            @(negedge clk);
            if (busy) cnt++; else break;
        end
        chk("clr_sweep_cycles", cnt, 1024);
        tick();
        model_clear();
        cfg_op(1'b0, 1'b1, 16'h0005, 0, rd, lat);
        chk("clr_rd_5", rd, 0);
        cfg_op(1'b0, 1'b1, 16'h0123, 0, rd, lat);
        chk("clr_rd_123", rd, 0);

        // Reset in the middle of a sweep restarts it from index 0.
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        repeat (300) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        mon_en = 1'b0;
        q.delete();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_busy", busy, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_write", ram_en && ram_we, 1);
        chk("midrst_first_addr", ram_addr, 0);
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 3000 && cnt > 0; i++) begin
            @(negedge clk);
            if (busy) cnt++; else break;
        end
        chk("midrst_sweep_cycles", cnt, 1024);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
